// File: rtl/jcv_pkg.sv
// Shared opcodes, flag indices, return-stack entry and FSM state for jump_ctrl_vectored.
// Entry fields are sized for the widest supported build: AW <= 16, NUM_IRQ <= 7.
package jcv_pkg;

    localparam logic [5:0] OP_JMP = 6'h18;
    localparam logic [5:0] OP_JZ  = 6'h1C;
    localparam logic [5:0] OP_JNZ = 6'h1D;
    localparam logic [5:0] OP_JV  = 6'h1E;
    localparam logic [5:0] OP_JNV = 6'h1F;
    localparam logic [5:0] OP_RET = 6'h10;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_V = 1;

    localparam int unsigned JCV_AW_MAX    = 16;
    localparam int unsigned JCV_LVL_W_MAX = 3;

    typedef struct packed {
        logic [JCV_AW_MAX-1:0]    addr;
        logic [1:0]               flags;
        logic [JCV_LVL_W_MAX-1:0] level;
    } stack_entry_t;

    typedef enum logic [0:0] {
        StRun,
        StRedirect
    } jcv_state_e;

endpackage

// File: rtl/jump_ctrl_vectored_irq_prio_enc.sv
// Priority encoder over the pending vector; index 0 wins.
module irq_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan from lowest priority upward so the last hit is the winner.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/jump_ctrl_vectored.sv
// Jump/return resolution with prioritised, vectored, nestable interrupts and a return stack.
// Optional macro JCV_IRQ_MASK_EN adds irq_mask to gate lines out of the priority select.
module jump_ctrl_vectored
    import jcv_pkg::*;
#(
    parameter int unsigned   AW          = 16,
    parameter int unsigned   NUM_IRQ     = 4,
    parameter int unsigned   STACK_DEPTH = 4,
    parameter logic [AW-1:0] VEC_BASE    = 16'hF000,
    parameter int unsigned   VEC_STRIDE  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AW-1:0]      jmp_address_pm,
    input  logic [AW-1:0]      current_address,
    input  logic [5:0]         op,
    input  logic [1:0]         flag_ex,
    input  logic [NUM_IRQ-1:0] irq,
`ifdef JCV_IRQ_MASK_EN
    input  logic [NUM_IRQ-1:0] irq_mask,
`endif
    output logic [AW-1:0]      jmp_loc,
    output logic               pc_mux_sel,
    output logic [1:0]         flag_restore,
    output logic               flag_restore_valid,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               in_isr,
    output logic               ret_underflow
);

    localparam int unsigned IW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned LW  = $clog2(NUM_IRQ + 1);
    localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    jcv_state_e         state_q;
    logic [NUM_IRQ-1:0] irq_prev_q, pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_rise, pend_all, eligible, take_onehot;
    logic [SPW-1:0]     sp_q, sp_d;
    logic [LW-1:0]      level_q, level_d;
    logic [AW-1:0]      jmp_loc_q, loc_d;
    logic [1:0]         flag_restore_q;
    logic               flag_restore_valid_q, in_isr_q, ret_underflow_q;
    logic [NUM_IRQ-1:0] irq_ack_q;

    stack_entry_t       stack_q [STACK_DEPTH];
    stack_entry_t       top_entry, push_entry;
    logic [SIW-1:0]     top_idx, push_idx;

    logic               prio_valid;
    logic [IW-1:0]      prio_idx;
    logic               stack_full, stack_empty;
    logic               take, is_ret, ret_pop, ret_under, jump_cond, jump, redirect;

    assign irq_rise = irq & ~irq_prev_q;
    assign pend_all = pending_q | irq_rise;

`ifdef JCV_IRQ_MASK_EN
    assign eligible = pend_all & irq_mask;
`else
    assign eligible = pend_all;
`endif

    irq_prio_enc #(
        .N  (NUM_IRQ),
        .IW (IW)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (prio_valid),
        .idx_o   (prio_idx)
    );

    assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign top_idx     = SIW'(sp_q - 1'b1);
    assign push_idx    = SIW'(sp_q);
    assign top_entry   = stack_q[top_idx];

    always_comb begin
        push_entry       = '0;
        push_entry.addr  = JCV_AW_MAX'(current_address);
        push_entry.flags = flag_ex;
        push_entry.level = JCV_LVL_W_MAX'(level_q);
    end

    always_comb begin
        jump_cond = 1'b0;
        case (op)
            OP_JMP:  jump_cond = 1'b1;
            OP_JZ:   jump_cond = flag_ex[FLAG_Z];
            OP_JNZ:  jump_cond = ~flag_ex[FLAG_Z];
            OP_JV:   jump_cond = flag_ex[FLAG_V];
            OP_JNV:  jump_cond = ~flag_ex[FLAG_V];
            default: jump_cond = 1'b0;
        endcase
    end

    // Interrupt take beats RET, RET beats jump; a taken interrupt discards the decode op.
    always_comb begin
        take        = prio_valid && (LW'(prio_idx) < level_q) && !stack_full;
        is_ret      = (op == OP_RET);
        ret_pop     = !take && is_ret && !stack_empty;
        ret_under   = !take && is_ret && stack_empty;
        jump        = !take && !is_ret && jump_cond;
        redirect    = take || ret_pop || jump;
        take_onehot = take ? (NUM_IRQ'(1) << prio_idx) : '0;
        pending_d   = pend_all & ~take_onehot;
        sp_d        = sp_q;
        level_d     = level_q;
        loc_d       = jmp_loc_q;
        if (take) begin
            sp_d    = sp_q + 1'b1;
            level_d = LW'(prio_idx);
            loc_d   = VEC_BASE + AW'(32'(prio_idx) * VEC_STRIDE);
        end else if (ret_pop) begin
            sp_d    = sp_q - 1'b1;
            level_d = LW'(top_entry.level);
            loc_d   = AW'(top_entry.addr);
        end else if (jump) begin
            loc_d   = jmp_address_pm;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q              <= StRun;
            irq_prev_q           <= '0;
            pending_q            <= '0;
            sp_q                 <= '0;
            level_q              <= LW'(NUM_IRQ);
            jmp_loc_q            <= '0;
            flag_restore_q       <= '0;
            flag_restore_valid_q <= 1'b0;
            irq_ack_q            <= '0;
            in_isr_q             <= 1'b0;
            ret_underflow_q      <= 1'b0;
        end else begin
            state_q              <= redirect ? StRedirect : StRun;
            irq_prev_q           <= irq;
            pending_q            <= pending_d;
            sp_q                 <= sp_d;
            level_q              <= level_d;
            jmp_loc_q            <= loc_d;
            flag_restore_valid_q <= ret_pop;
            irq_ack_q            <= take_onehot;
            in_isr_q             <= (sp_d != '0);
            ret_underflow_q      <= ret_underflow_q | ret_under;
            if (ret_pop) begin
                flag_restore_q <= top_entry.flags;
            end
        end
    end

    // Stack contents need no reset: only slots below sp_q are ever read.
    always_ff @(posedge clk) begin
        if (reset && take) begin
            stack_q[push_idx] <= push_entry;
        end
    end

    assign jmp_loc            = jmp_loc_q;
    assign pc_mux_sel         = (state_q == StRedirect);
    assign flag_restore       = flag_restore_q;
    assign flag_restore_valid = flag_restore_valid_q;
    assign irq_ack            = irq_ack_q;
    assign in_isr             = in_isr_q;
    assign ret_underflow      = ret_underflow_q;

endmodule

// File: doc/jump_ctrl_vectored.md
Name: jump_ctrl_vectored

Overview:
- Parametrised successor to the 16-bit jump control block in the MIPS fetch path.
- Resolves unconditional and flag-conditional jumps and returns from the decode-stage opcode.
- Adds NUM_IRQ prioritised, vectored, nestable interrupts backed by a return stack that saves the return address, the flags and the interrupted level.
- Drives jmp_loc and pc_mux_sel to the PC mux.

Parameters:
- AW, 16: address width.
- NUM_IRQ, 4: interrupt lines; index 0 has the highest priority.
- STACK_DEPTH, 4: maximum interrupt nesting depth.
- VEC_BASE, 16'hF000: vector of line 0 (AW bits).
- VEC_STRIDE, 4: address spacing between consecutive vectors.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- jmp_address_pm  in  AW  jump target from program memory.
- current_address  in  AW  address of the instruction currently in decode.
- op  in  6  decode opcode.
- flag_ex  in  2  execute flags: [1]=overflow V, [0]=zero Z.
- irq  in  NUM_IRQ  level interrupt requests; rising-edge detected.
- jmp_loc  out  AW  redirect target.
- pc_mux_sel  out  1  1 = PC loads jmp_loc.
- flag_restore  out  2  flags popped by RET.
- flag_restore_valid  out  1  one-cycle strobe with flag_restore.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle pulse when a line is vectored.
- in_isr  out  1  stack non-empty.
- ret_underflow  out  1  sticky; set by RET on an empty stack.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs 0.
  - Stack pointer 0, pending register 0, edge-detect history 0.
  - Current level = NUM_IRQ (meaning idle).
- Opcodes (decided in cycle N):
  - 6'h18 JMP: always taken.
  - 6'h1C JZ: taken if Z.
  - 6'h1D JNZ: taken if !Z.
  - 6'h1E JV: taken if V.
  - 6'h1F JNV: taken if !V.
  - 6'h10 RET: pops the stack.
  - Any other opcode: no action.
- Latency: all outputs are registered. A decision made in cycle N appears in cycle N+1, for exactly one cycle. pc_mux_sel is 0 otherwise; jmp_loc holds its last value.
- Pending logic: a 0->1 transition on irq[i] sets pending[i]. pending[i] clears only on the cycle that line is taken.
- Interrupt take condition: pending non-zero, highest-priority pending index p < current level, and stack not full.
  - Push {current_address, flag_ex, current level}.
  - Current level becomes p.
  - jmp_loc = VEC_BASE + p*VEC_STRIDE, truncated to AW; pc_mux_sel=1; irq_ack[p]=1.
  - The decode op in the same cycle is discarded. It is re-fetched on return because the pushed address is current_address, not +1.
- Priority when events coincide in one cycle: interrupt take > RET > jump. Reset overrides everything.
- RET with stack non-empty:
  - Pop; jmp_loc = saved address; pc_mux_sel=1.
  - flag_restore = saved flags; flag_restore_valid=1.
  - Restore the saved level.
- RET with stack empty: no redirect; ret_underflow set until reset.
- Stack full: pending lines stay latched and are taken after a RET frees a slot and the priority condition holds.
- Lower- or equal-priority pending lines wait until the current level is raised by RET.
- FSM states: RUN (default), REDIRECT (one cycle while outputs are asserted; new decisions are still evaluated in this cycle), back to RUN. Ops arriving in the cycle after a redirect are treated as flushed by the pipeline; the block still evaluates them.

Optional Feature:
- Macro: JCV_IRQ_MASK_EN.
- Defined:
  - Adds input irq_mask[NUM_IRQ].
  - A masked line still latches pending but is excluded from the priority select.
  - Unmasking a pending line makes it eligible on the next cycle.
- Undefined: no port; all lines are always eligible.

Decomposition:
- Package jcv_pkg:
  - Opcode localparams OP_JMP, OP_JZ, OP_JNZ, OP_JV, OP_JNV, OP_RET.
  - Flag bit indices FLAG_Z=0, FLAG_V=1.
  - Stack-entry struct {addr, flags, level}.
- Sub-module irq_prio_enc: parametrised priority encoder that takes the pending vector and outputs valid plus index.

Test Plan:
- Reset held low for 2 cycles, then op=6'h18 with jmp_address_pm=16'h0008 -> next cycle pc_mux_sel=1, jmp_loc=16'h0008; the cycle after, pc_mux_sel=0.
- flag_ex=2'b01: op=6'h1C -> taken; op=6'h1D -> pc_mux_sel stays 0; flag_ex=2'b10 with op=6'h1E -> taken.
- Rising edge on irq[2] with current_address=16'h0040 -> jmp_loc=16'hF008, irq_ack=4'b0100, in_isr=1; then op=6'h10 -> jmp_loc=16'h0040 and flag_restore equal to the flags at entry.
- Inside the irq[2] ISR: irq[3] rises -> not taken; irq[0] rises -> nests to 16'hF000. Two RETs unwind in LIFO order, then irq[3] is taken.
- STACK_DEPTH=2, nesting 2 deep, a higher line pending -> no redirect until RET; RET on an empty stack -> ret_underflow=1.
- irq edge and op=6'h18 in the same cycle -> vector taken and the pushed address equals that cycle's current_address. Reset mid-ISR -> in_isr=0 and pending cleared.
